// File: rtl/signed_divider_seq_pkg.sv
// Shared state encoding and sizing helpers for the sequential signed divider.
package signed_divider_seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StIter  = 2'd2,
        StSign  = 2'd3
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/absolute_value.sv
// Two's-complement magnitude; |-2^(W-1)| is returned as the unsigned value 2^(W-1).
module absolute_value #(
    parameter int unsigned Width = 16
) (
    input  logic [Width-1:0] value_i,
    output logic [Width-1:0] mag_o
);

    always_comb begin
        mag_o = value_i[Width-1] ? (~value_i + Width'(1)) : value_i;
    end

endmodule

// File: rtl/give_sign.sv
// Applies a sign to an unsigned magnitude (negates when neg_i is set).
module give_sign #(
    parameter int unsigned Width = 16
) (
    input  logic [Width-1:0] mag_i,
    input  logic             neg_i,
    output logic [Width-1:0] value_o
);

    always_comb begin
        value_o = neg_i ? (~mag_i + Width'(1)) : mag_i;
    end

endmodule

// File: rtl/signed_divider_seq_div_step.sv
// One restoring shift-subtract iteration on the {R,Q} pair.
module signed_divider_seq_div_step #(
    parameter int unsigned Width = 16
) (
    input  logic [Width-1:0] r_i,
    input  logic [Width-1:0] q_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] r_o,
    output logic [Width-1:0] q_o
);

    logic [Width:0] r_sh;
    logic [Width:0] diff;
    logic           ge;

    always_comb begin
        r_sh = {r_i, q_i[Width-1]};
        diff = r_sh - {1'b0, d_i};
        // r_sh < 2*d always, so the top bit of diff is exactly the borrow
        ge   = ~diff[Width];
        r_o  = ge ? diff[Width-1:0] : r_sh[Width-1:0];
        q_o  = {q_i[Width-2:0], ge};
    end

endmodule

// File: rtl/signed_divider_seq.sv
// Multi-cycle signed divider with RISC-V DIV/REM semantics.
// Define DIVIDER_UNSIGNED_EN to add a Signed input selecting unsigned operation.
module signed_divider_seq
    import signed_divider_seq_pkg::*;
#(
    parameter int unsigned l = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic [l-1:0] Dividend,
    input  logic [l-1:0] Divisor,
`ifdef DIVIDER_UNSIGNED_EN
    input  logic         Signed,
`endif
    output logic         Busy,
    output logic         Done,
    output logic [l-1:0] Quotient,
    output logic [l-1:0] Remainder,
    output logic         DivByZero,
    output logic         Overflow
);

    localparam int unsigned    CntW   = cnt_width(l);
    localparam logic [CntW-1:0] CntMax = CntW'(l - 1);
    localparam logic [l-1:0]    MinVal = {1'b1, {(l-1){1'b0}}};

    state_e        state_q, state_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [l-1:0]  quot_q, quot_d, rem_q, rem_d;
    logic          dbz_q, dbz_d, ovf_q, ovf_d;
    logic [l-1:0]  dvd_q, dvd_d, dvs_q, dvs_d;
    logic          neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [l-1:0]  r_q, r_d, q_q, q_d, dmag_q, dmag_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic          signed_op;
    logic [l-1:0]  dvd_abs, dvs_abs, r_step, q_step, q_signed, r_signed;
    logic          div_zero, ovf_case;

`ifdef DIVIDER_UNSIGNED_EN
    assign signed_op = Signed;
`else
    assign signed_op = 1'b1;
`endif

    absolute_value #(.Width(l)) u_abs_dvd (.value_i(dvd_q), .mag_o(dvd_abs));
    absolute_value #(.Width(l)) u_abs_dvs (.value_i(dvs_q), .mag_o(dvs_abs));

    signed_divider_seq_div_step #(.Width(l)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (dmag_q),
        .r_o (r_step),
        .q_o (q_step)
    );

    give_sign #(.Width(l)) u_sign_q (.mag_i(q_q), .neg_i(neg_a_q ^ neg_b_q), .value_o(q_signed));
    give_sign #(.Width(l)) u_sign_r (.mag_i(r_q), .neg_i(neg_a_q), .value_o(r_signed));

    // Sign bits are only latched for signed operations, so they also gate the overflow case
    assign div_zero = (dvs_q == '0);
    assign ovf_case = neg_a_q && neg_b_q && (dvd_q == MinVal) && (dvs_q == '1);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        r_d     = r_q;
        q_d     = q_q;
        dmag_d  = dmag_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    dvd_d   = Dividend;
                    dvs_d   = Divisor;
                    neg_a_d = signed_op & Dividend[l-1];
                    neg_b_d = signed_op & Divisor[l-1];
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                r_d     = '0;
                q_d     = neg_a_q ? dvd_abs : dvd_q;
                dmag_d  = neg_b_q ? dvs_abs : dvs_q;
                cnt_d   = '0;
                state_d = (div_zero || ovf_case) ? StSign : StIter;
            end
            StIter: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntMax) begin
                    state_d = StSign;
                end
            end
            StSign: begin
                if (div_zero) begin
                    quot_d = '1;
                    rem_d  = dvd_q;
                    dbz_d  = 1'b1;
                end else if (ovf_case) begin
                    quot_d = MinVal;
                    rem_d  = '0;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = q_signed;
                    rem_d  = r_signed;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            r_q     <= '0;
            q_q     <= '0;
            dmag_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dmag_q  <= dmag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivByZero = dbz_q;
    assign Overflow  = ovf_q;

endmodule
